// File: rtl/param_data_memory.sv
// Byte-enabled word memory with a fixed-latency in-order response pipe
// and an optional zero-fill sweep after reset.
module param_data_memory #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 7,
  parameter int DEPTH          = 128,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    resp_valid,
  output logic                    resp_write,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic                    busy
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int RL   = READ_LATENCY;

  localparam logic [ADDR_WIDTH:0] DEPTH_W =
    (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR =
    ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  accept;
  logic                  in_range;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_wa;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic [BE_W-1:0]       mem_wbe;

  logic [RL-1:0]         vld_q, vld_d;
  logic [RL-1:0]         wr_q, wr_d;
  logic [RL-1:0]         err_q, err_d;
  logic [DATA_WIDTH-1:0] data_q [RL];
  logic [DATA_WIDTH-1:0] data_d [RL];

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_CLEAR);
  assign accept    = req_valid & req_ready & ~reset;
  assign in_range  = {1'b0, req_addr} < DEPTH_W;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mem_we  = 1'b0;
    mem_wa  = ptr_q;
    mem_wd  = '0;
    mem_wbe = '1;
    unique case (state_q)
      ST_CLEAR: begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == LAST_PTR) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end
      end
      ST_IDLE: begin
        if (accept && req_write && in_range) begin
          mem_we  = 1'b1;
          mem_wa  = req_addr;
          mem_wd  = req_wdata;
          mem_wbe = req_be;
        end
      end
      default: ;
    endcase
  end

  // Stage 0 captures the read word at acceptance; later stages only delay.
  always_comb begin
    vld_d     = '0;
    wr_d      = '0;
    err_d     = '0;
    for (int i = 0; i < RL; i++) begin
      data_d[i] = '0;
    end
    vld_d[0] = accept;
    wr_d[0]  = accept & req_write;
    err_d[0] = accept & ~in_range;
    if (accept && !req_write && in_range) begin
      data_d[0] = mem_q[req_addr];
    end
    for (int i = 1; i < RL; i++) begin
      vld_d[i]  = vld_q[i-1];
      wr_d[i]   = wr_q[i-1];
      err_d[i]  = err_q[i-1];
      data_d[i] = data_q[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      ptr_q   <= '0;
      vld_q   <= '0;
      wr_q    <= '0;
      err_q   <= '0;
      for (int i = 0; i < RL; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      vld_q   <= vld_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      for (int i = 0; i < RL; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && mem_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (mem_wbe[b]) begin
          mem_q[mem_wa][8*b +: 8] <= mem_wd[8*b +: 8];
        end
      end
    end
  end

  assign resp_valid = vld_q[RL-1];
  assign resp_write = wr_q[RL-1];
  assign resp_err   = err_q[RL-1];
  assign resp_rdata = data_q[RL-1];

endmodule

// File: tb/tb_param_data_memory.sv
// Randomized scoreboard bench for param_data_memory with an
// out-of-range region (DEPTH < 2^ADDR_WIDTH) and multi-cycle latency.
module tb_param_data_memory;

  localparam int DW    = 32;
  localparam int AW    = 7;
  localparam int DEPTH = 100;
  localparam int RL    = 3;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_be;
  logic          resp_valid;
  logic          resp_write;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic          busy;

  param_data_memory #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .DEPTH         (DEPTH),
    .READ_LATENCY  (RL),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clock      (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (resp_valid),
    .resp_write (resp_write),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  typedef struct {
    bit          w;
    bit          err;
    logic [31:0] d;
    int          acc;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] model [DEPTH];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          mon_en   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               nm, got, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per observed response.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_resp: got valid expected none (t=%0t)",
                   $time);
        end else begin
          e = exp_q.pop_front();
          chk("resp_write", 64'(resp_write), 64'(e.w));
          chk("resp_err", 64'(resp_err), 64'(e.err));
          chk("resp_rdata", 64'(resp_rdata), 64'(e.d));
          chk("resp_latency", 64'(cyc - e.acc), 64'(RL - 1));
        end
      end else begin
        chk("idle_zero", 64'({resp_write, resp_err, resp_rdata}), 64'd0);
      end
    end
  end

  // Called just after a negedge; returns just after the accepting edge.
  task automatic send(input bit w, input int a,
                      input logic [31:0] d, input logic [3:0] be);
    int   guard;
    exp_t e;
    guard     = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = AW'(a);
    req_wdata = d;
    req_be    = be;
    while (!req_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      chk("send_timeout", 64'd1, 64'd0);
    end else begin
      e.w   = w;
      e.err = (a >= DEPTH);
      e.d   = '0;
      e.acc = cyc + 1;
      if (a < DEPTH) begin
        if (w) begin
          for (int i = 0; i < 4; i++)
            if (be[i]) model[a][8*i +: 8] = d[8*i +: 8];
        end else begin
          e.d = model[a];
        end
      end
      exp_q.push_back(e);
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic sweep(input int limit, input int expect_n);
    int n;
    n = 0;
    while (busy && n < limit) begin
      chk("sweep_ready_low", 64'(req_ready), 64'd0);
      n++;
      @(negedge clk);
    end
    chk("sweep_len", 64'(n), 64'(expect_n));
  endtask

  task automatic readback();
    for (int a = 0; a < (1 << AW); a++) send(1'b0, a, '0, '0);
  endtask

  initial begin
    int guard;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    @(negedge clk);
    do_reset();
    mon_en = 1'b1;
    chk("reset_busy", 64'(busy), 64'd1);
    sweep(1000, DEPTH);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_ready", 64'(req_ready), 64'd1);
    readback();

    send(1'b1, 11, 32'h0000_0050, 4'hf);
    send(1'b0, 11, '0, '0);
    send(1'b1, 5, 32'hAABB_CCDD, 4'hf);
    send(1'b1, 5, 32'h1122_3344, 4'h5);
    send(1'b0, 5, '0, '0);
    send(1'b1, 5, 32'hFFFF_FFFF, 4'h0);
    send(1'b0, 5, '0, '0);
    send(1'b1, 120, 32'hDEAD_BEEF, 4'hf);
    send(1'b0, 120, '0, '0);
    send(1'b1, 99, 32'h1234_5678, 4'hf);
    send(1'b1, 100, 32'h8765_4321, 4'hf);
    send(1'b0, 99, '0, '0);
    for (int a = 11; a <= 20; a++) send(1'b0, a, '0, '0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
      end else begin
        send(1'($urandom_range(0, 1)), $urandom_range(0, 127),
             $urandom, 4'($urandom_range(0, 15)));
      end
    end
    readback();

    send(1'b0, 11, '0, '0);
    send(1'b0, 12, '0, '0);
    do_reset();
    sweep(60, 60);
    do_reset();
    sweep(1000, DEPTH);
    chk("resweep_ready", 64'(req_ready), 64'd1);
    readback();

    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
